// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: forwarding selects, load-use/branch stall-flush, multi-cycle multiply sequencing.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned MUL_LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  Rs1E,
   input  logic [4:0]  Rs2E,
   input  logic [4:0]  RdE,
   input  logic [4:0]  RdM,
   input  logic [4:0]  RdW,
   input  logic        RegWriteM,
   input  logic        RegWriteW,
   input  logic        ResultSrcE0,
   input  logic        PCSrcE,
   input  logic        MulStartE,
   output logic        StallF,
   output logic        StallD,
   output logic        StallE,
   output logic        FlushD,
   output logic        FlushE,
   output logic        FlushM,
   output logic [1:0]  ForwardAE,
   output logic [1:0]  ForwardBE,
   output logic        MulBusy,
   output logic [15:0] StallCnt,
   output logic [15:0] FlushCnt
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       lw_stall, mul_start, mul_hold;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                          input logic wr_m, input logic [4:0] rd_w,
                                          input logic wr_w);
      if (wr_m && (rd_m != 5'd0) && (rs == rd_m))      return 2'b10;
      else if (wr_w && (rd_w != 5'd0) && (rs == rd_w)) return 2'b01;
      else                                             return 2'b00;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (MulStartE && !PCSrcE) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
         end
         BUSY: if (cnt_q == 4'd0) state_d = IDLE;
               else               cnt_d   = cnt_q - 4'd1;
         default: state_d = IDLE;
      endcase
   end

   assign lw_stall  = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
   assign mul_start = (state_q == IDLE) && MulStartE && !PCSrcE;
   // The final BUSY cycle already follows idle rules so the next instruction advances.
   assign mul_hold  = (state_q == BUSY) && (cnt_q != 4'd0);

   // NOTE: every output gets a default first, so no path leaves a latch behind.
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      MulBusy   = 1'b0;
      if (rst_n) begin
         ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
         ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
         MulBusy   = (state_q == BUSY);
         if (mul_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
         end else begin
            StallF = lw_stall || mul_start;
            StallD = lw_stall || mul_start;
            StallE = mul_start;
            FlushM = mul_start;
            FlushD = PCSrcE;
            FlushE = lw_stall || PCSrcE;
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (StallD && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (FlushD && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 16'h0000;
         flush_cnt_q <= 16'h0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`else
   assign StallCnt = 16'h0000;
   assign FlushCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int MUL_LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic        RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulStartE;
   logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [15:0] StallCnt, FlushCnt;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MulBusy(MulBusy),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   int checks = 0;
   int errors = 0;

   // Model state: BUSY cycles still to come for the current multiply, and counter values.
   int busy_left   = 0;
   int stall_cnt_m = 0;
   int flush_cnt_m = 0;

   // Last sampled DUT outputs: {StallF,StallD,StallE,FlushD,FlushE,FlushM,MulBusy,FwdA,FwdB}
   logic [10:0] last_ctrl;
   logic [15:0] last_sc, last_fc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && rs == RdM) return 2'b10;
      if (RegWriteW && RdW != 0 && rs == RdW) return 2'b01;
      return 2'b00;
   endfunction

   task automatic clear_inputs();
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulStartE} = '0;
   endtask

   // Called 1 time unit after a rising edge with inputs already applied.
   task automatic step(input string tag);
      logic        lw, busy, hold, start;
      logic        sf, sd, se, fd, fe, fm;
      logic [10:0] exp;
      logic [15:0] exp_sc, exp_fc;
      start = 1'b0;
      #4;
      if (!rst_n) begin
         exp         = '0;
         busy_left   = 0;
         stall_cnt_m = 0;
         flush_cnt_m = 0;
      end else begin
         lw    = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
         busy  = busy_left > 0;
         hold  = busy_left > 1;
         start = !busy && MulStartE && !PCSrcE;
         if (hold) {sf, sd, se, fd, fe, fm} = 6'b111_001;
         else begin
            sf = lw | start;
            sd = lw | start;
            se = start;
            fm = start;
            fd = PCSrcE;
            fe = lw | PCSrcE;
         end
         exp = {sf, sd, se, fd, fe, fm, busy, fwd_ref(Rs1E), fwd_ref(Rs2E)};
      end
`ifdef HAZ_PERF_CNT_EN
      exp_sc = 16'(stall_cnt_m);
      exp_fc = 16'(flush_cnt_m);
`else
      exp_sc = 16'h0000;
      exp_fc = 16'h0000;
`endif
      last_ctrl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, ForwardAE, ForwardBE};
      last_sc   = StallCnt;
      last_fc   = FlushCnt;
      check({tag, "_ctrl"}, 32'(last_ctrl), 32'(exp));
      check({tag, "_scnt"}, 32'(last_sc), 32'(exp_sc));
      check({tag, "_fcnt"}, 32'(last_fc), 32'(exp_fc));
      @(posedge clk);
      if (rst_n) begin
         if (busy_left > 0) busy_left--;
         else if (start)    busy_left = MUL_LAT - 1;
         if (exp[9] && stall_cnt_m < 65535) stall_cnt_m++;
         if (exp[7] && flush_cnt_m < 65535) flush_cnt_m++;
      end
      #1;
   endtask

   int se_cycles, busy_cycles, fm_cycles;
   logic pulse_fd;

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      @(posedge clk); #1;
      step("reset");
      step("reset");
      rst_n = 1'b1;
      step("idle");

      // Forwarding priority and x0 exclusion
      RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
      step("fwd_mem");
      check("fwd_mem_prio", 32'(last_ctrl[3:2]), 32'(2'b10));
      RdM = 0; Rs1E = 0;
      step("fwd_x0");
      check("fwd_x0_sel", 32'(last_ctrl[3:2]), 32'(2'b00));
      clear_inputs();

      // Load-use stall lasts while the condition holds
      ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
      step("lw_use");
      check("lw_stall_sd_fe", 32'({last_ctrl[10:9], last_ctrl[6]}), 32'(3'b111));
      ResultSrcE0 = 0;
      step("lw_done");
      check("lw_released", 32'({last_ctrl[10:9], last_ctrl[6]}), 32'(3'b000));

      // Branch with load-use and multiply request: branch wins
      ResultSrcE0 = 1; PCSrcE = 1; MulStartE = 1;
      step("br_lw_mul");
      check("br_flush_stall", 32'({last_ctrl[7:6], last_ctrl[9]}), 32'(3'b111));
      clear_inputs();
      step("br_after");
      check("br_no_mul", 32'(last_ctrl[4]), 32'(0));

      // Multiply sequence with a branch pulse while busy
      se_cycles = 0; busy_cycles = 0; fm_cycles = 0; pulse_fd = 1'b0;
      MulStartE = 1;
      step("mul_start");
      se_cycles += int'(last_ctrl[8]); busy_cycles += int'(last_ctrl[4]); fm_cycles += int'(last_ctrl[5]);
      MulStartE = 0;
      for (int i = 0; i < 5; i++) begin
         PCSrcE = (i == 1);
         step("mul_run");
         if (i == 1) pulse_fd = last_ctrl[7];
         se_cycles += int'(last_ctrl[8]); busy_cycles += int'(last_ctrl[4]); fm_cycles += int'(last_ctrl[5]);
      end
      PCSrcE = 0;
      check("mul_stalle_cycles", 32'(se_cycles), 32'(MUL_LAT - 1));
      check("mul_busy_cycles", 32'(busy_cycles), 32'(MUL_LAT - 1));
      check("mul_flushm_cycles", 32'(fm_cycles), 32'(MUL_LAT - 1));
      check("mul_branch_ignored", 32'(pulse_fd), 32'(0));

      // Asynchronous reset in the second BUSY cycle
      MulStartE = 1;
      step("rst_mul_start");
      MulStartE = 0;
      step("rst_busy1");
      rst_n = 1'b0;
      step("rst_mid");
      check("rst_all_zero", 32'(last_ctrl), 32'(0));
      rst_n = 1'b1;
      step("rst_release");
      check("rst_idle", 32'(last_ctrl[4]), 32'(0));

`ifdef HAZ_PERF_CNT_EN
      rst_n = 1'b0;
      step("perf_rst");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
         step("perf_lw");
         clear_inputs();
         step("perf_gap");
      end
      PCSrcE = 1;
      step("perf_br");
      PCSrcE = 0;
      step("perf_gap");
      check("perf_stall_cnt", 32'(last_sc), 32'(3));
      check("perf_flush_cnt", 32'(last_fc), 32'(1));
      ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
      for (int i = 0; i < 70000; i++) step("perf_sat");
      clear_inputs();
      step("perf_end");
      check("perf_stall_sat", 32'(last_sc), 32'(16'hFFFF));
`endif

      // Randomized traffic over a small register window to provoke matches
      for (int i = 0; i < 2000; i++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         RegWriteM   = 1'($urandom_range(0, 1));
         RegWriteW   = 1'($urandom_range(0, 1));
         ResultSrcE0 = ($urandom_range(0, 2) == 0);
         PCSrcE      = ($urandom_range(0, 7) == 0);
         MulStartE   = ($urandom_range(0, 5) == 0);
         rst_n       = ($urandom_range(0, 99) != 0);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard controller for the five-stage pipeline. It generates the stall and flush controls for the F/D pipeline register and the D/E/M stage registers, and the forwarding selects for the execute-stage operand muxes. It also sequences multi-cycle multiply operations by freezing the front of the pipeline while a multiply occupies Execute. The block sits beside the datapath and consumes register addresses and control bits from the D, E, M and W stages.

## Interface
- MUL_LAT, 4: total cycles a multiply holds Execute; legal range 2..16.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode.
- Rs1E, Rs2E  in  5  source registers of the instruction in Execute.
- RdE, RdM, RdW  in  5  destination registers in Execute, Memory and Writeback.
- RegWriteM, RegWriteW  in  1  destination write enable in Memory and Writeback.
- ResultSrcE0  in  1  the instruction in Execute is a load.
- PCSrcE  in  1  branch/jump taken, resolved in Execute.
- MulStartE  in  1  the instruction in Execute is a multiply.
- StallF, StallD, StallE  out  1  hold PC, F/D register and D/E register.
- FlushD, FlushE, FlushM  out  1  clear F/D, D/E and E/M registers.
- ForwardAE, ForwardBE  out  2  operand select: 00 = register file, 10 = Memory result, 01 = Writeback result.
- MulBusy  out  1  multiply sequencer not idle.
- StallCnt, FlushCnt  out  16  performance counters (see Configuration).

## Operation
- Forwarding is combinational. ForwardAE = 10 when RegWriteM, RdM != 0 and Rs1E == RdM. Otherwise it is 01 when RegWriteW, RdW != 0 and Rs1E == RdW. Otherwise it is 00. ForwardBE is computed the same way using Rs2E.
- Load-use: lwStall = ResultSrcE0 & (RdE != 0) & (Rs1D == RdE | Rs2D == RdE).
- Multiply FSM states are IDLE and BUSY, plus a 4-bit down-counter cnt.
- IDLE behaviour:
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - StallE = FlushM = 0.
- IDLE transition: if MulStartE & !PCSrcE, then StallF = StallD = StallE = 1 and FlushM = 1 in that same cycle. Next state is BUSY with cnt = MUL_LAT-2.
- BUSY behaviour:
  - StallF = StallD = StallE = 1 and FlushM = 1.
  - FlushD = FlushE = 0.
  - lwStall, PCSrcE and MulStartE are ignored.
- BUSY transition: if cnt == 0, the next state is IDLE and all stalls release on the following cycle. Otherwise cnt decrements.
- The multiply therefore occupies Execute for exactly MUL_LAT cycles. On the last of those cycles the outputs follow IDLE rules with MulStartE masked, so the next instruction advances.
- MulBusy = (state == BUSY).
- If MulStartE and PCSrcE are both high, PCSrcE wins and the multiply is not started.
- Reset (rst_n low, asynchronous): state = IDLE, cnt = 0, counters = 0. While rst_n is low all outputs are forced to 0, including the forwarding selects.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the current state, with zero-cycle latency. They are sampled by the pipeline registers at the next rising clk.
- A multiply with MulStartE high at edge N-1 (in IDLE) holds E through edges N..N+MUL_LAT-2. MulBusy is high for MUL_LAT-1 cycles.
- Deasserting rst_n mid-BUSY aborts the sequence. The first cycle after release is IDLE.
- A load-use stall lasts one cycle per occurrence. Back-to-back hazards restall on each cycle the condition holds.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - StallCnt increments every cycle StallD = 1.
  - FlushCnt increments every cycle FlushD = 1.
  - Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- HAZ_PERF_CNT_EN undefined: no counter flops are built, and StallCnt and FlushCnt are tied to 16'h0000.

## Test plan
- Forwarding: RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1, Rs1E = 5 -> ForwardAE = 10 (Memory has priority). Same with RdM = 0 and Rs1E = 0 -> ForwardAE = 00.
- Load-use: ResultSrcE0 = 1, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for one cycle, then 0 once ResultSrcE0 drops.
- Branch: PCSrcE = 1 together with lwStall -> FlushD = FlushE = 1 and StallD = 1. MulStartE asserted in the same cycle -> MulBusy stays 0.
- Multiply with MUL_LAT = 4: MulStartE pulse -> StallE = 1 for 3 cycles, MulBusy = 1 for 3 cycles, FlushM = 1 for 3 cycles, then all return to 0. A PCSrcE pulse during BUSY -> no flush.
- Reset: drop rst_n during the second BUSY cycle -> all outputs 0 immediately. After release, state is IDLE and MulBusy = 0.
- With HAZ_PERF_CNT_EN: 3 load-use stalls plus 1 branch -> StallCnt = 3, FlushCnt = 1. Forcing 70000 stall cycles -> StallCnt = 16'hFFFF.
